// File: rtl/rgb_rx.sv
// Receiver for the single-wire RGB pulse-width protocol: measures each high pulse,
// classifies it as 1/0 (or a glitch) and assembles bytes MSB-first; a long low ends the frame.
module rgb_rx #(
    parameter int CNT_W  = 16,
    parameter int SYNC_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic [CNT_W-1:0] min_hi,
    input  logic [CNT_W-1:0] hi_thresh,
    input  logic [CNT_W-1:0] gap_len,
    output logic [7:0]       data,
    output logic             data_valid,
    output logic             frame_end,
    output logic             bit_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_N-1:0] sync_reg;
    logic              s_prev_reg;
    logic              s;
    logic              rise;
    logic              fall;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  hcnt_reg, hcnt_next;
    logic [CNT_W-1:0]  lcnt_reg, lcnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        data_reg, data_next;
    logic              dv_reg, dv_next;
    logic              fe_reg, fe_next;
    logic              err_reg, err_next;

    logic [CNT_W-1:0]  gap_eff;
    logic [7:0]        shifted;
    logic              bit_val;

    // s_prev keeps tracking the line even when disabled, so re-enabling mid-pulse sees no rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg   <= '0;
            s_prev_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_N-2:0], din};
            s_prev_reg <= sync_reg[SYNC_N-1];
        end
    end

    assign s       = sync_reg[SYNC_N-1];
    assign rise    = s & ~s_prev_reg;
    assign fall    = ~s & s_prev_reg;
    assign gap_eff = (gap_len == '0) ? CNT_ONE : gap_len;

    always_comb begin
        state_next   = state_reg;
        hcnt_next    = hcnt_reg;
        lcnt_next    = lcnt_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        data_next    = data_reg;
        dv_next      = 1'b0;
        fe_next      = 1'b0;
        err_next     = 1'b0;
        bit_val      = (hcnt_reg >= hi_thresh);
        shifted      = {shift_reg[6:0], bit_val};

        if (!en) begin
            state_next   = IDLE;
            hcnt_next    = '0;
            lcnt_next    = '0;
            shift_next   = '0;
            bit_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        state_next = HIGH;
                        hcnt_next  = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_next = LOW;
                        lcnt_next  = CNT_ONE;
                        if (hcnt_reg < min_hi) begin
                            err_next     = 1'b1;
                            shift_next   = '0;
                            bit_cnt_next = '0;
                        end else begin
                            shift_next = shifted;
                            if (bit_cnt_reg == 3'd7) begin
                                data_next    = shifted;
                                dv_next      = 1'b1;
                                bit_cnt_next = '0;
                            end else begin
                                bit_cnt_next = bit_cnt_reg + 3'd1;
                            end
                        end
                    end else if (hcnt_reg != '1) begin
                        hcnt_next = hcnt_reg + CNT_ONE;
                    end
                end
                LOW: begin
                    // The latch gap wins over a rise arriving in the same cycle.
                    if (lcnt_reg >= gap_eff) begin
                        state_next   = IDLE;
                        fe_next      = 1'b1;
                        shift_next   = '0;
                        bit_cnt_next = '0;
                    end else if (rise) begin
                        state_next = HIGH;
                        hcnt_next  = CNT_ONE;
                    end else if (lcnt_reg != '1) begin
                        lcnt_next = lcnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            hcnt_reg    <= '0;
            lcnt_reg    <= '0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            data_reg    <= '0;
            dv_reg      <= 1'b0;
            fe_reg      <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hcnt_reg    <= hcnt_next;
            lcnt_reg    <= lcnt_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            data_reg    <= data_next;
            dv_reg      <= dv_next;
            fe_reg      <= fe_next;
            err_reg     <= err_next;
        end
    end

    assign data       = data_reg;
    assign data_valid = dv_reg;
    assign frame_end  = fe_reg;
    assign bit_err    = err_reg;
    assign busy       = (state_reg != IDLE);

endmodule
